draw_char_16x16: RTL and testbench
==================================

// Module: draw_char_16x16
// PURPOSE
//  Text-overlay stage of the VGA pixel pipeline; consumer side of the 16x16 text ROM / font ROM pair.
//  From incoming pixel counters it generates char_xy/char_line addresses for the text ROM.
//  Takes the font row (char_pixels) returned by the synchronous font ROM and overlays glyph pixels on rgb.
//  Timing signals are delayed so that all outputs stay aligned.
//  Sits between the background/rect draw stages and the VGA output register.
// PARAMETERS
//  X_POS       100     left edge of text area, pixels (0..895)
//  Y_POS       100     top edge of text area, pixels (0..511)
//  TEXT_COLOR  12'hF_F_F  rgb for glyph pixels (bit=1)
//  BG_COLOR    12'h0_0_0  rgb for non-glyph pixels inside area (TEXT_BG_EN only)
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   async reset, active low
//  hcount_in    in   11  horizontal pixel counter
//  vcount_in    in   11  vertical pixel counter
//  hsync_in     in   1   h sync
//  vsync_in     in   1   v sync
//  hblnk_in     in   1   h blank
//  vblnk_in     in   1   v blank
//  rgb_in       in   12  upstream colour
//  char_xy      out  8   [7:4] text row 0..15, [3:0] text column 0..15 -> text ROM
//  char_line    out  4   pixel line within glyph 0..15 -> font ROM (via text ROM)
//  char_pixels  in   8   font row, bit7 = leftmost pixel; valid 1 clk after char_xy/char_line
//  hcount_out.. out  --  hcount/vcount/hsync/vsync/hblnk/vblnk/rgb_out, same widths as inputs
// BEHAVIOUR
//  - Glyph cell 8x16 px; text area 128x256 px.
//  - Area test, unsigned: in_area = X_POS<=h<X_POS+128 && Y_POS<=v<Y_POS+256.
//  - rel_x = h-X_POS, rel_y = v-Y_POS.
//  - Stage 1 (registered): char_xy = {rel_y[7:4], rel_x[6:3]}, char_line = rel_y[3:0].
//    * When !in_area: char_xy=0, char_line=0.
//    * Also latches bit_sel = rel_x[2:0], in_area, and all timing/rgb.
//  - Stage 2: char_pixels valid; registers pix = char_pixels[7-bit_sel_d1].
//    * Also delays in_area and the timing/rgb signals.
//  - Stage 3 (output register):
//    * draw = in_area_d2 & !hblnk_d2 & !vblnk_d2.
//    * rgb_out = draw&pix ? TEXT_COLOR : rgb_d2.
//  - Latency: exactly 3 clk, input -> every *_out. char_xy/char_line lead rgb_out by 2 clk.
//  - Boundaries:
//    * Last area pixel h = X_POS+127 is column 15, bit 0.
//    * h = X_POS+128 is outside the area (pass-through).
//    * Counter wrap from line end to 0 needs no special handling (pure pipeline).
//  - Reset (async assert, sync-deasserted upstream):
//    * All pipeline regs and outputs = 0: rgb_out=0, syncs=0, blnk=0, counts=0, char_xy=0, char_line=0.
//  - Reset mid-frame: pipeline flushed to 0. First valid outputs 3 clk after first post-reset edge.
//  - No handshake; one pixel per clk, no stalls.
// CONFIGURATION
//  TEXT_BG_EN defined:
//    * In-area non-glyph pixels (draw & !pix) output BG_COLOR.
//    * Text box visible as a solid block.
//  TEXT_BG_EN undefined:
//    * Non-glyph pixels pass rgb_d2 unchanged.
//    * BG_COLOR unused.
// TESTING
//  1. rst_n=0 mid-stream -> all outputs 0 immediately (async); after release, first valid rgb_out 3 clk later.
//  2. Latency: drive h=5,v=5 (outside area), rgb_in=12'h123 -> rgb_out=12'h123, hcount_out=5, 3 clk later; char_xy=0.
//  3. Addressing, X_POS=Y_POS=100: h=100+8*3+2, v=100+16*7+5 -> 1 clk later char_xy=8'h73, char_line=4'd5.
//  4. Glyph, same pixel, ROM model returns char_pixels=8'b0010_0000 -> rgb_out=TEXT_COLOR; neighbours bit_sel 1,3 -> rgb_in.
//  5. Edges, all-ones font: h=X_POS+127 -> TEXT_COLOR; h=X_POS+128 and v=Y_POS+256 -> rgb_in; hblnk_in=1 in area -> rgb_in.
//  6. TEXT_BG_EN, BG_COLOR=12'h00F, char_pixels=0 in area -> rgb_out=12'h00F; outside -> rgb_in.

Source files
------------

// File: rtl/draw_char_16x16.sv
// draw_char_16x16 -- text overlay stage of the VGA pixel pipeline.
// Generates text ROM addresses (char_xy/char_line) from the pixel counters,
// picks the glyph bit out of the font row returned one clock later and paints
// TEXT_COLOR over rgb. All timing signals are delayed 3 clocks to stay aligned.
// Optional feature macro: TEXT_BG_EN (in-area non-glyph pixels -> BG_COLOR).
module draw_char_16x16 #(
  parameter int          X_POS      = 100,
  parameter int          Y_POS      = 100,
  parameter logic [11:0] TEXT_COLOR = 12'hF_F_F,
  parameter logic [11:0] BG_COLOR   = 12'h0_0_0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Text area bounds, widened to 12 bits so X_POS+128 / Y_POS+256 never wrap.
  localparam logic [11:0] LP_X0 = 12'(X_POS);
  localparam logic [11:0] LP_X1 = 12'(X_POS + 128);
  localparam logic [11:0] LP_Y0 = 12'(Y_POS);
  localparam logic [11:0] LP_Y1 = 12'(Y_POS + 256);

  // Timing bundle carried down the pipe untouched.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } tim_t;

  logic       w_in_area;
  logic [6:0] w_rel_x;
  logic [7:0] w_rel_y;
  tim_t       w_tim_in;

  tim_t       r_tim1, r_tim2;
  logic       r_area1, r_area2;
  logic [2:0] r_bit_sel1;
  logic       r_pix2;
  logic [7:0] r_char_xy;
  logic [3:0] r_char_line;

  logic        w_draw;
  logic [11:0] w_rgb_nxt;

  // Area test and offsets within the text box (only low bits are meaningful).
  always_comb begin
    w_in_area = ({1'b0, hcount_in} >= LP_X0) && ({1'b0, hcount_in} < LP_X1) &&
                ({1'b0, vcount_in} >= LP_Y0) && ({1'b0, vcount_in} < LP_Y1);
    w_rel_x   = 7'(hcount_in - LP_X0[10:0]);
    w_rel_y   = 8'(vcount_in - LP_Y0[10:0]);
    w_tim_in  = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                  vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
  end

  // Stage 1: ROM address, bit select and timing capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_char_xy   <= '0;
      r_char_line <= '0;
      r_bit_sel1  <= '0;
      r_area1     <= 1'b0;
      r_tim1      <= '0;
    end else begin
      r_char_xy   <= w_in_area ? {w_rel_y[7:4], w_rel_x[6:3]} : 8'h00;
      r_char_line <= w_in_area ? w_rel_y[3:0] : 4'h0;
      r_bit_sel1  <= w_rel_x[2:0];
      r_area1     <= w_in_area;
      r_tim1      <= w_tim_in;
    end
  end

  // Stage 2: font row is valid now; keep only the selected pixel (bit7 = leftmost).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix2  <= 1'b0;
      r_area2 <= 1'b0;
      r_tim2  <= '0;
    end else begin
      r_pix2  <= char_pixels[3'd7 - r_bit_sel1];
      r_area2 <= r_area1;
      r_tim2  <= r_tim1;
    end
  end

  // Colour select: glyph pixels only inside the area and outside blanking.
  always_comb begin
    w_draw = r_area2 & ~r_tim2.hblnk & ~r_tim2.vblnk;
`ifdef TEXT_BG_EN
    w_rgb_nxt = w_draw ? (r_pix2 ? TEXT_COLOR : BG_COLOR) : r_tim2.rgb;
`else
    w_rgb_nxt = (w_draw & r_pix2) ? TEXT_COLOR : r_tim2.rgb;
`endif
  end

  // Stage 3: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= r_tim2.hcount;
      vcount_out <= r_tim2.vcount;
      hsync_out  <= r_tim2.hsync;
      vsync_out  <= r_tim2.vsync;
      hblnk_out  <= r_tim2.hblnk;
      vblnk_out  <= r_tim2.vblnk;
      rgb_out    <= w_rgb_nxt;
    end
  end

  assign char_xy   = r_char_xy;
  assign char_line = r_char_line;

endmodule

// File: tb/tb_draw_char_16x16.sv
// Directed bench for draw_char_16x16 (X_POS=Y_POS=100, TEXT_COLOR=FFF, BG_COLOR=00F).
module tb_draw_char_16x16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [7:0]  rom_row;   // font row the ROM model returns for any address
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [11:0] TXT = 12'hFFF;
  localparam logic [11:0] BG  = 12'h00F;

  draw_char_16x16 #(
    .X_POS(100), .Y_POS(100), .TEXT_COLOR(TXT), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .char_xy(char_xy), .char_line(char_line), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // ROM model: row presented in the cycle after the address, sampled by stage 2.
  assign char_pixels = rom_row;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input bit hb, input bit vb,
                       input bit hs, input bit vs, input logic [11:0] rgb);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = hs;
    vsync_in  = vs;
    rgb_in    = rgb;
  endtask

  // One pixel followed by a filler pixel; address checked 1 clk in, outputs 3 clk in.
  task automatic run(input string tag, input int h, input int v, input bit hb, input bit vb,
                     input bit hs, input bit vs, input logic [11:0] rgb,
                     input logic [7:0] exy, input logic [3:0] eline, input logic [11:0] ergb);
    @(negedge clk);
    drive(h, v, hb, vb, hs, vs, rgb);
    @(posedge clk); #1;
    chk({tag, ".xy"}, 32'(char_xy), 32'(exy));
    chk({tag, ".line"}, 32'(char_line), 32'(eline));
    @(negedge clk);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC);
    @(posedge clk); #1;
    chk({tag, ".early"}, 32'(hcount_out == 11'(h) && rgb_out == ergb && h != 0), 32'(0));
    @(posedge clk); #1;
    chk({tag, ".rgb"}, 32'(rgb_out), 32'(ergb));
    chk({tag, ".hcnt"}, 32'(hcount_out), 32'(h));
    chk({tag, ".vcnt"}, 32'(vcount_out), 32'(v));
    chk({tag, ".tim"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'({hs, vs, hb, vb}));
  endtask

  logic [11:0] nonglyph;

  initial begin
`ifdef TEXT_BG_EN
    nonglyph = BG;
`else
    nonglyph = 12'h555;
`endif
    rom_row = 8'h00;
    rst_n   = 1'b0;
    drive(300, 300, 1'b0, 1'b0, 1'b1, 1'b1, 12'h777);
    #1;
    chk("rst.rgb", 32'(rgb_out), 32'(0));
    chk("rst.xy", 32'({char_xy, char_line}), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("rst.hold", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Outside area: pass-through, latency 3.
    run("lat", 5, 5, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123, 8'h00, 4'h0, 12'h123);

    // Glyph row 0010_0000 at column 3 bit 2, text row 7 line 5, plus neighbours.
    rom_row = 8'b0010_0000;
    run("glyph", 126, 217, 1'b0, 1'b0, 1'b0, 1'b1, 12'h555, 8'h73, 4'd5, TXT);
    run("nbr1",  125, 217, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555, 8'h73, 4'd5, nonglyph);
    run("nbr3",  127, 217, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555, 8'h73, 4'd5, nonglyph);

    // Edges with an all-ones font.
    rom_row = 8'hFF;
    run("last",  227, 217, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246, 8'h7F, 4'd5, TXT);
    run("hout",  228, 217, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246, 8'h00, 4'd0, 12'h246);
    run("vout",  126, 356, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246, 8'h00, 4'd0, 12'h246);
    run("first", 100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246, 8'h00, 4'd0, TXT);
    run("pre",    99, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246, 8'h00, 4'd0, 12'h246);
    run("bot",   227, 355, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246, 8'hFF, 4'd15, TXT);
    run("hblnk", 126, 217, 1'b1, 1'b0, 1'b0, 1'b0, 12'h246, 8'h73, 4'd5, 12'h246);
    run("vblnk", 126, 217, 1'b0, 1'b1, 1'b0, 1'b0, 12'h246, 8'h73, 4'd5, 12'h246);

    // Empty font row in area: background only with TEXT_BG_EN.
    rom_row = 8'h00;
    run("bg",    150, 150, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555, 8'h36, 4'd2, nonglyph);

    // Mid-stream reset: outputs clear asynchronously, then 3 clk to first valid.
    @(negedge clk);
    drive(7, 9, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst.rgb", 32'(rgb_out), 32'h321);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.rgb", 32'(rgb_out), 32'(0));
    chk("mid_rst.tim", 32'({hcount_out, vcount_out, hsync_out, vsync_out}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 8, 9, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 8'h00, 4'd0, 12'h321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
